// File: rtl/pipe_hazard_scoreboard_if.sv
// pipe_hazard_scoreboard_if: ID-side request and hazard/forwarding response bundle (optional WB bypass via PIPE_HAZARD_WB_BYPASS_EN)
interface pipe_hazard_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int CNT_W  = 32
);
  localparam int SELW = $clog2(DEPTH);
  logic              id_valid;
  logic [REG_AW-1:0] id_rs;
  logic [REG_AW-1:0] id_rt;
  logic              id_use_rs;
  logic              id_use_rt;
  logic              id_wr_en;
  logic [REG_AW-1:0] id_rd;
  logic              id_is_load;
  logic              flush;
  logic              stall;
  logic              pc_write;
  logic              if_id_write;
  logic              ex_valid;
  logic [SELW-1:0]   fwd_rs_sel;
  logic [SELW-1:0]   fwd_rt_sel;
  logic [CNT_W-1:0]  stall_cnt;
`ifdef PIPE_HAZARD_WB_BYPASS_EN
  logic              id_wb_byp_rs;
  logic              id_wb_byp_rt;
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load, flush,
    input  stall, pc_write, if_id_write, ex_valid, fwd_rs_sel, fwd_rt_sel, stall_cnt,
           id_wb_byp_rs, id_wb_byp_rt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load, flush,
    output stall, pc_write, if_id_write, ex_valid, fwd_rs_sel, fwd_rt_sel, stall_cnt,
           id_wb_byp_rs, id_wb_byp_rt
  );
`else
  modport master (
    output id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load, flush,
    input  stall, pc_write, if_id_write, ex_valid, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
  modport slave (
    input  id_valid, id_rs, id_rt, id_use_rs, id_use_rt, id_wr_en, id_rd, id_is_load, flush,
    output stall, pc_write, if_id_write, ex_valid, fwd_rs_sel, fwd_rt_sel, stall_cnt
  );
`endif
endinterface

// File: rtl/pipe_hazard_scoreboard.sv
// pipe_hazard_scoreboard: shift scoreboard giving load-use stalls and EX forwarding selects (PIPE_HAZARD_WB_BYPASS_EN adds WB bypass flags)
module pipe_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int ALU_AVAIL  = 1,
  parameter int LOAD_AVAIL = 2,
  parameter int CNT_W      = 32
) (
  input logic                    clk,
  input logic                    rst_n,
  pipe_hazard_scoreboard_if.slave bus
);
  localparam int SELW = $clog2(DEPTH);

  generate
    if (DEPTH < 2 || ALU_AVAIL < 1 || ALU_AVAIL > LOAD_AVAIL || LOAD_AVAIL > DEPTH - 1) begin : gCfgErr
      $error("pipe_hazard_scoreboard: illegal DEPTH/ALU_AVAIL/LOAD_AVAIL combination");
    end
  endgenerate

  logic [DEPTH-1:0]  slotValid, slotWr, slotLoad;
  logic [REG_AW-1:0] slotRd [DEPTH];
  logic [REG_AW-1:0] exRs, exRt;
  logic              exUseRs, exUseRt;
  logic              hazard, stallInt, take;
  logic [CNT_W-1:0]  stallCnt;

  function automatic logic slotMatch(input int k, input logic [REG_AW-1:0] r);
    return slotValid[k] && slotWr[k] && (slotRd[k] == r) && (r != '0);
  endfunction

  function automatic int slotAvail(input int k);
    return slotLoad[k] ? LOAD_AVAIL : ALU_AVAIL;
  endfunction

  // Only the youngest matching producer counts; older ones are shadowed by it.
  function automatic logic srcHazard(input logic [REG_AW-1:0] r, input logic used);
    logic found, haz;
    found = 1'b0;
    haz   = 1'b0;
    for (int j = 0; j < DEPTH - 1; j++)
      if (used && !found && slotMatch(j, r)) begin
        found = 1'b1;
        haz   = (j + 1 < slotAvail(j));
      end
    return haz;
  endfunction

  // Youngest match wins; if it is not yet forwardable the register file path is selected.
  function automatic logic [SELW-1:0] fwdSel(input logic [REG_AW-1:0] r, input logic used);
    logic            found;
    logic [SELW-1:0] sel;
    found = 1'b0;
    sel   = '0;
    for (int k = 1; k < DEPTH; k++)
      if (used && !found && slotMatch(k, r)) begin
        found = 1'b1;
        sel   = (k >= slotAvail(k)) ? SELW'(k) : '0;
      end
    return sel;
  endfunction

  assign hazard   = bus.id_valid && (srcHazard(bus.id_rs, bus.id_use_rs) || srcHazard(bus.id_rt, bus.id_use_rt));
  assign stallInt = hazard && !bus.flush;
  assign take     = bus.id_valid && !stallInt && !bus.flush;

  assign bus.stall       = stallInt;
  assign bus.pc_write    = !stallInt;
  assign bus.if_id_write = !stallInt;
  assign bus.ex_valid    = slotValid[0];
  assign bus.fwd_rs_sel  = fwdSel(exRs, slotValid[0] && exUseRs);
  assign bus.fwd_rt_sel  = fwdSel(exRt, slotValid[0] && exUseRt);
  assign bus.stall_cnt   = stallCnt;

`ifdef PIPE_HAZARD_WB_BYPASS_EN
  assign bus.id_wb_byp_rs = bus.id_use_rs && slotMatch(DEPTH - 1, bus.id_rs);
  assign bus.id_wb_byp_rt = bus.id_use_rt && slotMatch(DEPTH - 1, bus.id_rt);
`endif

  // Advance the scoreboard one stage per cycle; slot 0 takes the ID instruction or a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotValid <= '0;
      slotWr    <= '0;
      slotLoad  <= '0;
      for (int k = 0; k < DEPTH; k++) slotRd[k] <= '0;
      exRs      <= '0;
      exRt      <= '0;
      exUseRs   <= 1'b0;
      exUseRt   <= 1'b0;
    end else begin
      slotValid <= {slotValid[DEPTH-2:0], take};
      slotWr    <= {slotWr[DEPTH-2:0], bus.id_wr_en};
      slotLoad  <= {slotLoad[DEPTH-2:0], bus.id_is_load};
      for (int k = 1; k < DEPTH; k++) slotRd[k] <= slotRd[k-1];
      slotRd[0] <= bus.id_rd;
      exRs      <= bus.id_rs;
      exRt      <= bus.id_rt;
      exUseRs   <= bus.id_use_rs;
      exUseRt   <= bus.id_use_rt;
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stallCnt <= '0;
    else if (stallInt && stallCnt != '1) stallCnt <= stallCnt + 1'b1;
  end
endmodule

// File: tb/tb_pipe_hazard_scoreboard.sv
// tb_pipe_hazard_scoreboard: directed checks of stalls, forwarding, flush and reset on default and deep configurations
module tb_pipe_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   testCnt = 0;
  int   failCnt = 0;

  logic       idValid = 1'b0, useRs = 1'b0, useRt = 1'b0, wrEn = 1'b0, isLoad = 1'b0, flushIn = 1'b0;
  logic [4:0] rs = '0, rt = '0, rd = '0;

  always #5 clk = ~clk;

  pipe_hazard_scoreboard_if #(.REG_AW(5), .DEPTH(3), .CNT_W(32)) b0 ();
  pipe_hazard_scoreboard_if #(.REG_AW(5), .DEPTH(4), .CNT_W(32)) b1 ();

  assign b0.id_valid = idValid;   assign b1.id_valid = idValid;
  assign b0.id_rs = rs;           assign b1.id_rs = rs;
  assign b0.id_rt = rt;           assign b1.id_rt = rt;
  assign b0.id_use_rs = useRs;    assign b1.id_use_rs = useRs;
  assign b0.id_use_rt = useRt;    assign b1.id_use_rt = useRt;
  assign b0.id_wr_en = wrEn;      assign b1.id_wr_en = wrEn;
  assign b0.id_rd = rd;           assign b1.id_rd = rd;
  assign b0.id_is_load = isLoad;  assign b1.id_is_load = isLoad;
  assign b0.flush = flushIn;      assign b1.flush = flushIn;

  pipe_hazard_scoreboard #(.REG_AW(5), .DEPTH(3), .ALU_AVAIL(1), .LOAD_AVAIL(2), .CNT_W(32)) u0 (
    .clk(clk), .rst_n(rst_n), .bus(b0)
  );
  pipe_hazard_scoreboard #(.REG_AW(5), .DEPTH(4), .ALU_AVAIL(1), .LOAD_AVAIL(3), .CNT_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .bus(b1)
  );

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCnt++;
    if (got !== exp) begin
      failCnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] s, input logic [4:0] t, input logic us, input logic ut,
                       input logic w, input logic [4:0] d, input logic ld);
    idValid = v; rs = s; rt = t; useRs = us; useRt = ut; wrEn = w; rd = d; isLoad = ld;
    #1;
  endtask

  task automatic nop();
    drive(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  task automatic resetDut();
    rst_n = 1'b0;
    flushIn = 1'b0;
    nop();
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    nop();
    #2;
    checkEq("rst_stall", b0.stall, 0);
    checkEq("rst_pc_write", b0.pc_write, 1);
    checkEq("rst_if_id_write", b0.if_id_write, 1);
    checkEq("rst_ex_valid", b0.ex_valid, 0);
    checkEq("rst_fwd_rs", b0.fwd_rs_sel, 0);
    checkEq("rst_fwd_rt", b0.fwd_rt_sel, 0);
    checkEq("rst_cnt", b0.stall_cnt, 0);
    resetDut();

    // ALU producer then dependent consumer
    step(); drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
    checkEq("alu_p_stall", b0.stall, 0);
    step(); drive(1, 5'd3, 5'd1, 1, 1, 1, 5'd4, 0);
    checkEq("alu_c_stall", b0.stall, 0);
    step(); nop();
    checkEq("alu_ex_valid", b0.ex_valid, 1);
    checkEq("alu_fwd_rs", b0.fwd_rs_sel, 1);
    checkEq("alu_fwd_rt", b0.fwd_rt_sel, 0);
    resetDut();

    // load-use, default depth
    step(); drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
    step(); drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0);
    checkEq("lu_stall", b0.stall, 1);
    checkEq("lu_pc_write", b0.pc_write, 0);
    checkEq("lu_if_id_write", b0.if_id_write, 0);
    step();
    checkEq("lu_bubble", b0.ex_valid, 0);
    checkEq("lu_stall_release", b0.stall, 0);
    checkEq("lu_cnt_mid", b0.stall_cnt, 1);
    step(); nop();
    checkEq("lu_ex_valid", b0.ex_valid, 1);
    checkEq("lu_fwd_rs", b0.fwd_rs_sel, 2);
    checkEq("lu_fwd_rt", b0.fwd_rt_sel, 2);
    checkEq("lu_cnt", b0.stall_cnt, 1);
    resetDut();

    // load-use, DEPTH=4 LOAD_AVAIL=3
    step(); drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
    step(); drive(1, 5'd5, 5'd0, 1, 1, 1, 5'd6, 0);
    checkEq("d4_stall1", b1.stall, 1);
    step();
    checkEq("d4_stall2", b1.stall, 1);
    step();
    checkEq("d4_stall3", b1.stall, 0);
    checkEq("d4_cnt_mid", b1.stall_cnt, 2);
    step(); nop();
    checkEq("d4_ex_valid", b1.ex_valid, 1);
    checkEq("d4_fwd_rs", b1.fwd_rs_sel, 3);
    checkEq("d4_fwd_rt", b1.fwd_rt_sel, 0);
    checkEq("d4_cnt", b1.stall_cnt, 2);
    resetDut();

    // youngest producer wins; r0 never matches
    step(); drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
    step(); drive(1, 5'd1, 5'd2, 1, 1, 1, 5'd3, 0);
    step(); drive(1, 5'd3, 5'd0, 1, 1, 1, 5'd7, 0);
    checkEq("yw_stall", b0.stall, 0);
    step(); drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd0, 1);
    checkEq("yw_fwd_rs", b0.fwd_rs_sel, 1);
    checkEq("yw_fwd_rt", b0.fwd_rt_sel, 0);
    step(); drive(1, 5'd0, 5'd0, 1, 1, 1, 5'd8, 0);
    checkEq("r0_stall", b0.stall, 0);
    step(); nop();
    checkEq("r0_ex_valid", b0.ex_valid, 1);
    checkEq("r0_fwd_rs", b0.fwd_rs_sel, 0);
    checkEq("r0_fwd_rt", b0.fwd_rt_sel, 0);
    checkEq("r0_cnt", b0.stall_cnt, 0);
    resetDut();

    // flush beats a load-use hazard
    step(); drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
    step(); flushIn = 1'b1; drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0);
    checkEq("fl_stall", b0.stall, 0);
    checkEq("fl_pc_write", b0.pc_write, 1);
    checkEq("fl_if_id_write", b0.if_id_write, 1);
    step(); flushIn = 1'b0; nop();
    checkEq("fl_bubble", b0.ex_valid, 0);
    checkEq("fl_cnt", b0.stall_cnt, 0);
    resetDut();

    // asynchronous reset in the middle of a stall
    step(); drive(1, 5'd1, 5'd0, 1, 0, 1, 5'd5, 1);
    step(); drive(1, 5'd5, 5'd5, 1, 1, 1, 5'd6, 0);
    checkEq("ar_stall_pre", b0.stall, 1);
    rst_n = 1'b0;
    #1;
    checkEq("ar_stall_async", b0.stall, 0);
    checkEq("ar_pc_write_async", b0.pc_write, 1);
    step();
    checkEq("ar_ex_valid", b0.ex_valid, 0);
    rst_n = 1'b1;
    #1;
    checkEq("ar_stall_post", b0.stall, 0);
    step(); nop();
    checkEq("ar_consumer_ex", b0.ex_valid, 1);
    checkEq("ar_fwd_rs", b0.fwd_rs_sel, 0);
    checkEq("ar_cnt", b0.stall_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", testCnt, failCnt);
    $finish;
  end
endmodule
